tx_serializer: RTL and testbench

//  Transmit-side 10b-to-serial converter. Sits directly upstream of the TX electrical
//  sub-block (TX_I_O): takes 8b/10b-encoded symbols over a valid/ready handshake,

---
 rtl/tx_serializer_if.sv | 11 +
 rtl/tx_serializer.sv | 132 +++++++++++++
 tb/tb_tx_serializer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_serializer_if.sv
// Symbol handshake between the 8b/10b encoder (master) and tx_serializer (slave).
interface tx_serializer_if #(
    parameter int unsigned SIZE = 10
);
    logic [SIZE-1:0] SYMBOL_IN;
    logic            SYMBOL_VLD;
    logic            READY;

    modport master (output SYMBOL_IN, output SYMBOL_VLD, input READY);
    modport slave  (input SYMBOL_IN, input SYMBOL_VLD, output READY);
endinterface

// File: rtl/tx_serializer.sv
// Transmit-side symbol serializer: one-symbol hold buffer feeding a shift register,
// LSB first, with K28.5 fill or electrical idle on underrun.
module tx_serializer #(
    parameter int unsigned SIZE             = 10,
    parameter bit          FILL_ON_UNDERRUN = 1'b1
) (
    input  logic          TRANSCLK,
    input  logic          Reset,
    tx_serializer_if.slave sym_if,
    input  logic          TXIDLE_REQ,
    output logic          data,
    output logic          TXIDLE,
    output logic          SYMBOL_START,
    output logic          UNDERRUN
);
    localparam int unsigned      CNT_W    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);
    localparam logic [SIZE-1:0]  K285_RDN = SIZE'(10'b0101111100);
    localparam logic [SIZE-1:0]  K285_RDP = SIZE'(10'b1010000011);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SIZE-1:0]  hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [SIZE-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             data_q, data_d;
    logic             txidle_q, txidle_d;
    logic             start_q, start_d;
    logic             underrun_q, underrun_d;
    logic             rd_q, rd_d;

    logic             ready;
    logic             xfer;
    logic             boundary;
    logic [CNT_W-1:0] bit_cnt_inc;
    logic [SIZE-1:0]  fill_sym;

    assign ready        = ~hold_full_q & ~TXIDLE_REQ;
    assign sym_if.READY = ready;
    assign xfer         = sym_if.SYMBOL_VLD & ready;
    assign boundary     = (state_q == ST_IDLE) | (bit_cnt_q == LAST_BIT);
    assign bit_cnt_inc  = bit_cnt_q + CNT_W'(1);
    assign fill_sym     = rd_q ? K285_RDP : K285_RDN;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        txidle_d    = txidle_q;
        start_d     = 1'b0;
        underrun_d  = 1'b0;
        rd_d        = rd_q;

        // READY is low whenever the hold register is full, so a new transfer
        // and a boundary load of the hold register never collide.
        if (xfer) begin
            hold_d      = sym_if.SYMBOL_IN;
            hold_full_d = 1'b1;
        end

        if (boundary) begin
            if (hold_full_q) begin
                state_d     = ST_SHIFT;
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                bit_cnt_d   = '0;
                data_d      = hold_q[0];
                txidle_d    = 1'b0;
                start_d     = 1'b1;
            end else if (TXIDLE_REQ) begin
                state_d  = ST_IDLE;
                txidle_d = 1'b1;
                data_d   = 1'b0;
            end else if (state_q == ST_SHIFT) begin
                underrun_d = 1'b1;
                if (FILL_ON_UNDERRUN) begin
                    shift_d   = fill_sym;
                    bit_cnt_d = '0;
                    data_d    = fill_sym[0];
                    rd_d      = ~rd_q;
                    start_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    txidle_d = 1'b1;
                    data_d   = 1'b0;
                end
            end
        end else begin
            bit_cnt_d = bit_cnt_inc;
            data_d    = shift_q[bit_cnt_inc];
        end
    end

    always_ff @(posedge TRANSCLK) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            data_q      <= 1'b0;
            txidle_q    <= 1'b1;
            start_q     <= 1'b0;
            underrun_q  <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            txidle_q    <= txidle_d;
            start_q     <= start_d;
            underrun_q  <= underrun_d;
            rd_q        <= rd_d;
        end
    end

    assign data         = data_q;
    assign TXIDLE       = txidle_q;
    assign SYMBOL_START = start_q;
    assign UNDERRUN     = underrun_q;
endmodule

// File: tb/tb_tx_serializer.sv
// Bench for tx_serializer: a fill-mode and an idle-mode instance share one stimulus
// stream and are compared each cycle against a per-instance transmitter model.
module tb_tx_serializer;
    localparam int unsigned SIZE = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld   = 1'b0;
    logic       req   = 1'b0;
    logic [9:0] sym   = '0;
    logic [1:0] dout, tidle, ss, ur, rdy;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    tx_serializer_if #(.SIZE(SIZE)) if_f ();
    tx_serializer_if #(.SIZE(SIZE)) if_i ();

    assign if_f.SYMBOL_IN  = sym;
    assign if_f.SYMBOL_VLD = vld;
    assign if_i.SYMBOL_IN  = sym;
    assign if_i.SYMBOL_VLD = vld;
    assign rdy[0] = if_f.READY;
    assign rdy[1] = if_i.READY;

    tx_serializer #(.SIZE(SIZE), .FILL_ON_UNDERRUN(1'b1)) u_fill (
        .TRANSCLK(clk), .Reset(rst_n), .sym_if(if_f), .TXIDLE_REQ(req),
        .data(dout[0]), .TXIDLE(tidle[0]), .SYMBOL_START(ss[0]), .UNDERRUN(ur[0])
    );
    tx_serializer #(.SIZE(SIZE), .FILL_ON_UNDERRUN(1'b0)) u_idle (
        .TRANSCLK(clk), .Reset(rst_n), .sym_if(if_i), .TXIDLE_REQ(req),
        .data(dout[1]), .TXIDLE(tidle[1]), .SYMBOL_START(ss[1]), .UNDERRUN(ur[1])
    );

    // Reference transmitter: m=0 fills with K28.5, m=1 goes idle on underrun.
    // pos is the index of the bit on the line, -1 while not transmitting.
    logic       m_pend_v [2];
    logic [9:0] m_pend   [2];
    logic [9:0] m_cur    [2];
    int         m_pos    [2];
    logic       m_rd     [2];
    logic       e_data   [2];
    logic       e_idle   [2];
    logic       e_ss     [2];
    logic       e_ur     [2];

    always @(posedge clk) begin : model_b
        int         pos;
        logic       pv, rd, idle, ssx, urx, take;
        logic [9:0] cur;
        logic [9:0] kn, kp;
        kn = 10'b0101111100;
        kp = 10'b1010000011;
        for (int m = 0; m < 2; m++) begin
            pos  = m_pos[m];
            pv   = m_pend_v[m];
            cur  = m_cur[m];
            rd   = m_rd[m];
            idle = e_idle[m];
            ssx  = 1'b0;
            urx  = 1'b0;
            take = vld && !pv && !req;
            if (!rst_n) begin
                pv = 1'b0; pos = -1; rd = 1'b0; idle = 1'b1; cur = '0; take = 1'b0;
            end else if (pos < 0 || pos == SIZE - 1) begin
                if (pv) begin
                    cur = m_pend[m]; pv = 1'b0; pos = 0; idle = 1'b0; ssx = 1'b1;
                end else if (req) begin
                    pos = -1; idle = 1'b1;
                end else if (pos >= 0) begin
                    urx = 1'b1;
                    if (m == 0) begin
                        cur = rd ? kp : kn; rd = !rd; pos = 0; ssx = 1'b1;
                    end else begin
                        pos = -1; idle = 1'b1;
                    end
                end
            end else begin
                pos = pos + 1;
            end
            if (take) begin
                m_pend[m] <= sym;
                pv = 1'b1;
            end
            m_pend_v[m] <= pv;
            m_pos[m]    <= pos;
            m_cur[m]    <= cur;
            m_rd[m]     <= rd;
            e_idle[m]   <= idle;
            e_ss[m]     <= ssx;
            e_ur[m]     <= urx;
            e_data[m]   <= (pos >= 0) ? cur[pos] : 1'b0;
        end
    end

    function automatic logic [4:0] exp_vec(int m);
        return {e_data[m], e_idle[m], e_ss[m], e_ur[m], !m_pend_v[m] && !req};
    endfunction

    function automatic logic [4:0] dut_vec(int m);
        return {dout[m], tidle[m], ss[m], ur[m], rdy[m]};
    endfunction

    task automatic apply_reset(int n);
        rst_n = 1'b0; vld = 1'b0; req = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vld = 1'($urandom); sym = 10'($urandom); req = 1'($urandom);
            @(negedge clk);
        end
        req = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (dut_vec(m) !== 5'b01001) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b exp 01001 (data,idle,start,underrun,ready)", m, dut_vec(m));
            end
            checks++;
            if (dut_vec(m) !== exp_vec(m)) begin
                errors++;
                $display("FAIL reset_model dut%0d got %b exp %b", m, dut_vec(m), exp_vec(m));
            end
        end
        vld = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [9:0] want;
        want = 10'b1010100101;
        vld = 1'b1; sym = 10'h2A5; req = 1'b0;
        @(negedge clk);
        vld = 1'b0; req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({dout[m], ss[m], tidle[m]} !== {want[i], i == 0, 1'b0}) begin
                    errors++;
                    $display("FAIL single_bit%0d dut%0d got %b exp %b (data,start,idle)",
                             i, m, {dout[m], ss[m], tidle[m]}, {want[i], i == 0, 1'b0});
                end
                checks++;
                if (dut_vec(m) !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL single_model dut%0d got %b exp %b", m, dut_vec(m), exp_vec(m));
                end
            end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({tidle[m], ur[m], dout[m], ss[m]} !== 4'b1000) begin
                errors++;
                $display("FAIL single_idle dut%0d got %b exp 1000 (idle,underrun,data,start)",
                         m, {tidle[m], ur[m], dout[m], ss[m]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] syms [4];
        logic       r;
        int         idx, bitk;
        syms[0] = 10'h17C; syms[1] = 10'h283; syms[2] = 10'h0F0; syms[3] = 10'h30F;
        apply_reset(2);
        idx = 0; bitk = -1;
        for (int c = 0; c < 60; c++) begin
            vld = (idx < 4);
            sym = (idx < 4) ? syms[idx] : '0;
            r = rdy[0];
            @(negedge clk);
            if (vld && r) idx++;
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_vec(m) !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL b2b_model dut%0d c%0d got %b exp %b", m, c, dut_vec(m), exp_vec(m));
                end
            end
            if (bitk < 0 && ss[0]) bitk = 0;
            if (bitk >= 0 && bitk < 40) begin
                checks++;
                if ({dout[0], ss[0], ur[0]} !== {syms[bitk/10][bitk%10], bitk % 10 == 0, 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_bit%0d got %b exp %b (data,start,underrun)", bitk,
                             {dout[0], ss[0], ur[0]}, {syms[bitk/10][bitk%10], bitk % 10 == 0, 1'b0});
                end
                bitk++;
            end
        end
        vld = 1'b0;
        checks++;
        if (bitk != 40) begin
            errors++;
            $display("FAIL b2b_stream_len got %0d exp 40", bitk);
        end
    endtask

    task automatic test_underrun();
        logic [9:0] s, kn, kp, f;
        int         k;
        kn = 10'b0101111100;
        kp = 10'b1010000011;
        apply_reset(2);
        s = 10'($urandom);
        vld = 1'b1; sym = s;
        @(negedge clk);
        vld = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_vec(m) !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL underrun_model dut%0d c%0d got %b exp %b", m, c, dut_vec(m), exp_vec(m));
                end
            end
            if (c >= 11) begin
                k = c - 11;
                f = ((k / 10) % 2 == 0) ? kn : kp;
                checks++;
                if ({dout[0], ur[0], ss[0], tidle[0]} !== {f[k%10], k % 10 == 0, k % 10 == 0, 1'b0}) begin
                    errors++;
                    $display("FAIL fill_bit%0d got %b exp %b (data,underrun,start,idle)", k,
                             {dout[0], ur[0], ss[0], tidle[0]}, {f[k%10], k % 10 == 0, k % 10 == 0, 1'b0});
                end
                checks++;
                if ({ur[1], tidle[1], dout[1]} !== {c == 11, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL idle_underrun c%0d got %b exp %b (underrun,idle,data)", c,
                             {ur[1], tidle[1], dout[1]}, {c == 11, 1'b1, 1'b0});
                end
            end
        end
    endtask

    task automatic test_restart();
        logic [9:0] s;
        s = 10'($urandom);
        vld = 1'b1; sym = s;
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if ({ss[1], tidle[1]} !== 2'b01) begin
            errors++;
            $display("FAIL restart_early got %b exp 01 (start,idle)", {ss[1], tidle[1]});
        end
        @(negedge clk);
        checks++;
        if ({ss[1], tidle[1], dout[1]} !== {2'b10, s[0]}) begin
            errors++;
            $display("FAIL restart_first got %b exp %b (start,idle,data)", {ss[1], tidle[1], dout[1]}, {2'b10, s[0]});
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_vec(m) !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL restart_model dut%0d c%0d got %b exp %b", m, c, dut_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_reset_mid_symbol();
        apply_reset(2);
        vld = 1'b1; sym = 10'h155;
        @(negedge clk);
        sym = 10'h0AA;
        repeat (2) @(negedge clk);
        vld = 1'b0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if ({rdy[m], tidle[m]} !== 2'b00) begin
                errors++;
                $display("FAIL midsym_held dut%0d got %b exp 00 (ready,idle)", m, {rdy[m], tidle[m]});
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (dut_vec(m) !== 5'b01001) begin
                errors++;
                $display("FAIL midsym_reset dut%0d got %b exp 01001", m, dut_vec(m));
            end
        end
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if ({ss[m], tidle[m], dout[m]} !== 3'b010 || dut_vec(m) !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL midsym_discard dut%0d c%0d got %b exp %b", m, c, dut_vec(m), exp_vec(m));
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset(2);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (dut_vec(m) !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL random_model dut%0d c%0d got %b exp %b", m, c, dut_vec(m), exp_vec(m));
                end
            end
            vld = ($urandom_range(0, 3) != 0);
            sym = 10'($urandom);
            if ($urandom_range(0, 19) == 0) req = ~req;
            rst_n = ($urandom_range(0, 199) != 0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_restart();
        test_reset_mid_symbol();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
